// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: inter-stage bus widths, load type codes
// and the EXE->MEM bus layout.
package cpu_pkg;

  localparam int EXE_MEM_BUS_W = 76;
  localparam int MEM_WB_BUS_W  = 71;
  localparam int MEM_ID_BUS_W  = 39;

  // Bit position of mem_req inside the raw EXE->MEM bus.
  localparam int EMB_MEM_REQ = 74;

  // Load type codes carried in ld_type.
  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  // EXE->MEM bus, MSB first.
  typedef struct packed {
    logic        ex;
    logic        mem_req;
    logic        is_load;
    logic [2:0]  ld_type;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
  } exe_mem_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword of a 32-bit read
// word and sign- or zero-extends it according to the load type.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  ld_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword, then extend per load type.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (ld_type_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_BU:   data_o = {24'd0, byte_sel};
      LD_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;  // LD_W and unused codes return the word
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: waits for the data SRAM response of a load/store,
// buffers it when writeback stalls, aligns load data, and drops stale
// responses that belong to requests cancelled by a flush.
module mem_stage
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     EXE_to_MEM_valid,
  input  logic [EXE_MEM_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                     MEM_allowin,
  output logic                     MEM_to_WB_valid,
  output logic [MEM_WB_BUS_W-1:0]  MEM_to_WB_bus,
  input  logic                     WB_allowin,
  input  logic                     exec_flush,
  input  logic                     data_sram_data_ok,
  input  logic [31:0]              data_sram_rdata,
  output logic [MEM_ID_BUS_W-1:0]  MEM_to_ID_bus,
  output logic                     MEM_ex
);

  logic         mem_valid_q, mem_valid_d;
  exe_mem_bus_t bus_q;
  logic [31:0]  data_buf_q;
  logic         data_buf_valid_q, data_buf_valid_d;
  logic [1:0]   cancel_cnt_q, cancel_cnt_d;
  logic [2:0]   cancel_sum;

  logic         data_ok_live;
  logic         ready_go;
  logic         mem_leave;
  logic         buf_capture;
  logic         cancel_inc_cur, cancel_inc_up, cancel_dec;
  logic [31:0]  load_data, ext_data, final_result;
  logic         blocking_load;

  // A response only belongs to the current instruction once every
  // cancelled request has had its response swallowed.
  assign data_ok_live = data_sram_data_ok & (cancel_cnt_q == 2'd0);

  assign ready_go = ~bus_q.mem_req | bus_q.ex | data_buf_valid_q | data_ok_live;

  assign MEM_allowin     = ~mem_valid_q | (ready_go & WB_allowin);
  assign MEM_to_WB_valid = mem_valid_q & ready_go & ~exec_flush;
  assign mem_leave       = mem_valid_q & ready_go & WB_allowin;

  // Hold the response only when writeback cannot take it this cycle.
  assign buf_capture = data_ok_live & mem_valid_q & bus_q.mem_req & ~bus_q.ex
                     & ~WB_allowin & ~data_buf_valid_q;

  // The current request still has a response in flight unless it already
  // arrived (buffered or arriving now); a stale response this cycle does not count.
  assign cancel_inc_cur = exec_flush & mem_valid_q & bus_q.mem_req & ~bus_q.ex
                        & ~data_buf_valid_q & ~data_ok_live;
  // The instruction being dropped at the MEM input may have issued its request.
  assign cancel_inc_up  = exec_flush & EXE_to_MEM_valid & EXE_to_MEM_bus[EMB_MEM_REQ];
  assign cancel_dec     = data_sram_data_ok & (cancel_cnt_q != 2'd0);

  // Next-state for valid, buffer flag and cancel counter.
  always_comb begin
    mem_valid_d = mem_valid_q;
    if (exec_flush) begin
      mem_valid_d = 1'b0;
    end else if (MEM_allowin) begin
      mem_valid_d = EXE_to_MEM_valid;
    end

    data_buf_valid_d = data_buf_valid_q;
    if (exec_flush || mem_leave) begin
      data_buf_valid_d = 1'b0;
    end else if (buf_capture) begin
      data_buf_valid_d = 1'b1;
    end

    cancel_sum = {1'b0, cancel_cnt_q} + {2'b00, cancel_inc_cur}
               + {2'b00, cancel_inc_up} - {2'b00, cancel_dec};
    cancel_cnt_d = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q      <= 1'b0;
      data_buf_valid_q <= 1'b0;
      cancel_cnt_q     <= 2'd0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      data_buf_valid_q <= data_buf_valid_d;
      cancel_cnt_q     <= cancel_cnt_d;
    end
  end

  // Payload registers; only meaningful while their valid flags are set.
  always_ff @(posedge clk) begin
    if (EXE_to_MEM_valid && MEM_allowin && !exec_flush) begin
      bus_q <= EXE_to_MEM_bus;
    end
    if (buf_capture) begin
      data_buf_q <= data_sram_rdata;
    end
  end

  assign load_data = data_buf_valid_q ? data_buf_q : data_sram_rdata;

  load_align u_load_align (
    .rdata_i   (load_data),
    .offset_i  (bus_q.alu_result[1:0]),
    .ld_type_i (bus_q.ld_type),
    .data_o    (ext_data)
  );

  assign final_result  = bus_q.is_load ? ext_data : bus_q.alu_result;
  assign blocking_load = mem_valid_q & bus_q.is_load & ~ready_go;

  assign MEM_to_WB_bus = {bus_q.ex, bus_q.pc, bus_q.gr_we, bus_q.dest, final_result};
  assign MEM_to_ID_bus = {mem_valid_q & bus_q.gr_we & ~bus_q.ex, blocking_load,
                          bus_q.dest, final_result};
  assign MEM_ex        = mem_valid_q & (bus_q.ex | exec_flush);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset state, load alignment, response
// buffering under writeback stall, flush cancellation, ALU and exception paths.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXE_to_MEM_valid;
  logic [75:0] EXE_to_MEM_bus;
  logic        MEM_allowin;
  logic        MEM_to_WB_valid;
  logic [70:0] MEM_to_WB_bus;
  logic        WB_allowin;
  logic        exec_flush;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] MEM_to_ID_bus;
  logic        MEM_ex;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EXE_to_MEM_valid  (EXE_to_MEM_valid),
    .EXE_to_MEM_bus    (EXE_to_MEM_bus),
    .MEM_allowin       (MEM_allowin),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .WB_allowin        (WB_allowin),
    .exec_flush        (exec_flush),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .MEM_to_ID_bus     (MEM_to_ID_bus),
    .MEM_ex            (MEM_ex)
  );

  // Extension vectors: ld_type, address, read word, expected result.
  logic [2:0]  v_type [7] = '{3'd1, 3'd1, 3'd4, 3'd0, 3'd0, 3'd3, 3'd5};
  logic [31:0] v_alu  [7] = '{32'h6000, 32'h6002, 32'h6001, 32'h6000,
                              32'h6002, 32'h6001, 32'h6000};
  logic [31:0] v_rd   [7] = '{32'h1234_8765, 32'h7FFF_0000, 32'h0000_9A00, 32'h0000_007F,
                              32'h00C3_0000, 32'hCAFE_BABE, 32'hFFFF_F00D};
  logic [31:0] v_exp  [7] = '{32'hFFFF_8765, 32'h0000_7FFF, 32'h0000_009A, 32'h0000_007F,
                              32'hFFFF_FFC3, 32'hCAFE_BABE, 32'h0000_F00D};

  task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] mk_bus(input logic ex, input logic mem_req,
                                         input logic is_load, input logic [2:0] lt,
                                         input logic [31:0] pc, input logic we,
                                         input logic [4:0] dst, input logic [31:0] alu);
    return {ex, mem_req, is_load, lt, pc, we, dst, alu};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge; MEM must be empty.
  task automatic issue(input logic [75:0] b);
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus   = b;
    cyc();
    EXE_to_MEM_valid = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    EXE_to_MEM_valid  = 1'b0;
    EXE_to_MEM_bus    = '0;
    WB_allowin        = 1'b1;
    exec_flush        = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_allowin", MEM_allowin, 1);
    chk("rst_wb_valid", MEM_to_WB_valid, 0);
    chk("rst_mem_ex", MEM_ex, 0);
    $display("txn reset done");

    // ld.b at offset 3, response in the first MEM cycle
    issue(mk_bus(0, 1, 1, 3'd0, 32'h1C00_0010, 1, 5'd5, 32'h0000_1003));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    #1;
    chk("ldb_valid", MEM_to_WB_valid, 1);
    chk("ldb_wb_bus", MEM_to_WB_bus, {1'b0, 32'h1C00_0010, 1'b1, 5'd5, 32'hFFFF_FF80});
    chk("ldb_allowin", MEM_allowin, 1);
    $display("txn ld.b final=%h", MEM_to_WB_bus[31:0]);
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    chk("ldb_drained", MEM_to_WB_valid, 0);

    // ld.hu at offset 2 with writeback stalled for three cycles
    issue(mk_bus(0, 1, 1, 3'd5, 32'h1C00_0020, 1, 5'd6, 32'h0000_2002));
    WB_allowin = 1'b0;
    #1;
    chk("ldhu_wait_valid", MEM_to_WB_valid, 0);
    chk("ldhu_wait_block", MEM_to_ID_bus[37], 1);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    #1;
    chk("ldhu_ok_allowin", MEM_allowin, 0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("ldhu_buf_valid", MEM_to_WB_valid, 1);
    chk("ldhu_buf_data", MEM_to_WB_bus[31:0], 32'h0000_8001);
    cyc();
    WB_allowin = 1'b1;
    #1;
    chk("ldhu_rel_data", MEM_to_WB_bus[31:0], 32'h0000_8001);
    chk("ldhu_rel_allowin", MEM_allowin, 1);
    $display("txn ld.hu final=%h", MEM_to_WB_bus[31:0]);
    cyc();
    #1;
    chk("ldhu_drained", MEM_to_WB_valid, 0);

    // flush with an outstanding load; its late response must be dropped
    issue(mk_bus(0, 1, 1, 3'd2, 32'h1C00_0030, 1, 5'd7, 32'h0000_3000));
    exec_flush       = 1'b1;
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus   = mk_bus(0, 0, 0, 3'd2, 32'h1C00_0034, 1, 5'd8, 32'h0000_0042);
    #1;
    chk("fl_mem_ex", MEM_ex, 1);
    chk("fl_wb_valid", MEM_to_WB_valid, 0);
    cyc();
    exec_flush       = 1'b0;
    EXE_to_MEM_valid = 1'b0;
    #1;
    chk("fl_empty_valid", MEM_to_WB_valid, 0);
    chk("fl_empty_allowin", MEM_allowin, 1);
    issue(mk_bus(0, 1, 1, 3'd2, 32'h1C00_0040, 1, 5'd9, 32'h0000_4000));
    WB_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_AAAA;
    #1;
    chk("fl_stale_valid", MEM_to_WB_valid, 0);
    chk("fl_stale_block", MEM_to_ID_bus[37], 1);
    cyc();
    WB_allowin      = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    #1;
    chk("fl_own_valid", MEM_to_WB_valid, 1);
    chk("fl_own_data", MEM_to_WB_bus[31:0], 32'h1234_5678);
    $display("txn flush+reload final=%h", MEM_to_WB_bus[31:0]);
    cyc();
    data_sram_data_ok = 1'b0;

    // non-memory instruction passes straight through
    issue(mk_bus(0, 0, 0, 3'd0, 32'h1C00_0050, 1, 5'd9, 32'h0000_1234));
    #1;
    chk("alu_valid", MEM_to_WB_valid, 1);
    chk("alu_id_bus", MEM_to_ID_bus, {1'b1, 1'b0, 5'd9, 32'h0000_1234});
    $display("txn alu final=%h", MEM_to_WB_bus[31:0]);
    cyc();

    // excepting load does not wait for a response
    issue(mk_bus(1, 1, 1, 3'd2, 32'h1C00_0060, 1, 5'd3, 32'h0000_5000));
    #1;
    chk("ex_valid", MEM_to_WB_valid, 1);
    chk("ex_mem_ex", MEM_ex, 1);
    chk("ex_fwd_we", MEM_to_ID_bus[38], 0);
    chk("ex_block", MEM_to_ID_bus[37], 0);
    chk("ex_wb_ex", MEM_to_WB_bus[70], 1);
    $display("txn ex-load pc=%h", MEM_to_WB_bus[69:38]);
    cyc();

    // extension table
    for (int i = 0; i < 7; i++) begin
      issue(mk_bus(0, 1, 1, v_type[i], 32'h1C00_0100, 1, 5'd1, v_alu[i]));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = v_rd[i];
      #1;
      chk($sformatf("ext%0d", i), MEM_to_WB_bus[31:0], v_exp[i]);
      $display("txn ext%0d type=%0d final=%h", i, v_type[i], MEM_to_WB_bus[31:0]);
      cyc();
      data_sram_data_ok = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
